// File: rtl/ysyx_23060240_ifu_pkg.sv
// Shared constants for the instruction fetch unit: widths, filler instruction,
// FSM encoding and instruction-bus response codes.
package ysyx_23060240_ifu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060240_ifu_if.sv
// Fetch-side signal bundle: PC stage request, instruction bus read channels
// and the instruction handed to decode. The IFU takes the master modport.
interface ysyx_23060240_ifu_if;
  import ysyx_23060240_ifu_pkg::*;

  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            pc_ready_o;
  logic            flush_i;

  logic            ar_valid_o;
  logic            ar_ready_i;
  logic [XLEN-1:0] ar_addr_o;
  logic            r_valid_i;
  logic            r_ready_o;
  logic [31:0]     r_data_i;
  logic            r_err_i;

  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_fault_o;

  modport master (
    input  pc_i, pc_valid_i, flush_i,
    output pc_ready_o,
    output ar_valid_o, ar_addr_o, r_ready_o,
    input  ar_ready_i, r_valid_i, r_data_i, r_err_i,
    output inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
    input  inst_ready_i
  );

  modport slave (
    output pc_i, pc_valid_i, flush_i,
    input  pc_ready_o,
    input  ar_valid_o, ar_addr_o, r_ready_o,
    output ar_ready_i, r_valid_i, r_data_i, r_err_i,
    input  inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
    output inst_ready_i
  );

endinterface

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: one outstanding single-beat read per PC, result held
// for decode until accepted; flush squashes in-flight work, responses still drained.
module ysyx_23060240_ifu
  import ysyx_23060240_ifu_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  ysyx_23060240_ifu_if.master bus
);

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] req_pc;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            fault_q;

  logic pc_ready;
  logic take_req;
  logic take_mis;
  logic capture;

  // HOLD frees its slot on the decode handshake, so a new PC can enter back-to-back
  assign pc_ready = (state == S_IDLE) ||
                    ((state == S_HOLD) && bus.inst_ready_i && !bus.flush_i);

  assign take_req = pc_ready && bus.pc_valid_i && !pc_misaligned(bus.pc_i) && !bus.flush_i;
  assign take_mis = pc_ready && bus.pc_valid_i && pc_misaligned(bus.pc_i);
  assign capture  = (state == S_WAIT) && bus.r_valid_i && !bus.flush_i;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_mis)      state_nxt = S_HOLD;
        else if (take_req) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.ar_ready_i) state_nxt = bus.flush_i ? S_DROP : S_WAIT;
        else if (bus.flush_i) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (bus.flush_i)        state_nxt = bus.r_valid_i ? S_IDLE : S_DROP;
        else if (bus.r_valid_i) state_nxt = S_HOLD;
      end
      S_DROP: begin
        if (bus.r_valid_i) state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (bus.flush_i) state_nxt = S_IDLE;
        else if (bus.inst_ready_i) begin
          if (take_mis)      state_nxt = S_HOLD;
          else if (take_req) state_nxt = S_REQ;
          else               state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_pc    <= '0;
      inst_q    <= NOP_INST;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_req) req_pc <= bus.pc_i;
      if (take_mis) begin
        inst_q    <= NOP_INST;
        inst_pc_q <= bus.pc_i;
        fault_q   <= 1'b1;
      end else if (capture) begin
        inst_q    <= (bus.r_err_i == RESP_ERR) ? NOP_INST : bus.r_data_i;
        inst_pc_q <= req_pc;
        fault_q   <= (bus.r_err_i == RESP_ERR);
      end
    end
  end

  assign bus.pc_ready_o   = pc_ready;
  assign bus.ar_valid_o   = (state == S_REQ);
  // Only aligned PCs ever reach req_pc, so it is already a word address
  assign bus.ar_addr_o    = req_pc;
  assign bus.r_ready_o    = (state == S_WAIT) || (state == S_DROP);
  assign bus.inst_valid_o = (state == S_HOLD);
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = inst_pc_q;
  assign bus.inst_fault_o = fault_q;

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Directed bench for the fetch unit: reset, zero-wait fetch, backpressure,
// flush, faults and reset mid-transaction, with hand-computed expectations.
module tb_ysyx_23060240_ifu;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060240_ifu_if bus();

  ysyx_23060240_ifu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive a new PC in IDLE and step into REQ
  task automatic issue(input logic [31:0] pc);
    bus.pc_i = pc;
    bus.pc_valid_i = 1'b1;
    tick();
    bus.pc_valid_i = 1'b0;
  endtask

  // Complete the read with a zero-wait bus: accept in REQ, respond in WAIT
  task automatic bus_reply(input logic [31:0] data, input logic err);
    bus.ar_ready_i = 1'b1;
    tick();
    bus.ar_ready_i = 1'b0;
    bus.r_valid_i = 1'b1;
    bus.r_data_i = data;
    bus.r_err_i = err;
    tick();
    bus.r_valid_i = 1'b0;
    bus.r_err_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.pc_i = 32'h8000_0000;
    bus.pc_valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.ar_ready_i = 1'b0;
    bus.r_valid_i = 1'b0;
    bus.r_data_i = 32'h0;
    bus.r_err_i = 1'b0;
    bus.inst_ready_i = 1'b0;

    // 1. reset held two cycles with a request pending
    tick();
    tick();
    chk("rst_ar_valid", bus.ar_valid_o, 0);
    chk("rst_r_ready", bus.r_ready_o, 0);
    chk("rst_inst_valid", bus.inst_valid_o, 0);
    chk("rst_inst", bus.inst_o, 32'h13);
    chk("rst_inst_pc", bus.inst_pc_o, 0);
    chk("rst_fault", bus.inst_fault_o, 0);
    rst_n = 1'b1;
    settle();
    chk("idle_pc_ready", bus.pc_ready_o, 1);
    issue(32'h8000_0000);
    chk("req_ar_valid", bus.ar_valid_o, 1);
    chk("req_ar_addr", bus.ar_addr_o, 32'h8000_0000);
    chk("req_pc_ready", bus.pc_ready_o, 0);

    // 2. zero-wait fetch
    bus.ar_ready_i = 1'b1;
    tick();
    bus.ar_ready_i = 1'b0;
    chk("wait_r_ready", bus.r_ready_o, 1);
    chk("wait_ar_valid", bus.ar_valid_o, 0);
    bus.r_valid_i = 1'b1;
    bus.r_data_i = 32'h0010_0093;
    tick();
    bus.r_valid_i = 1'b0;
    chk("hold_valid", bus.inst_valid_o, 1);
    chk("hold_inst", bus.inst_o, 32'h0010_0093);
    chk("hold_pc", bus.inst_pc_o, 32'h8000_0000);
    chk("hold_fault", bus.inst_fault_o, 0);
    chk("hold_pc_ready_lo", bus.pc_ready_o, 0);
    bus.inst_ready_i = 1'b1;
    settle();
    chk("hold_pc_ready_hs", bus.pc_ready_o, 1);
    tick();
    bus.inst_ready_i = 1'b0;
    chk("post_hs_valid", bus.inst_valid_o, 0);

    // 3. backpressure on both the bus request and decode
    issue(32'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ar_valid", bus.ar_valid_o, 1);
      chk("bp_ar_addr", bus.ar_addr_o, 32'h8000_0008);
      tick();
    end
    bus_reply(32'h0020_8113, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_inst_valid", bus.inst_valid_o, 1);
      chk("bp_inst", bus.inst_o, 32'h0020_8113);
      chk("bp_inst_pc", bus.inst_pc_o, 32'h8000_0008);
      chk("bp_pc_ready", bus.pc_ready_o, 0);
      tick();
    end
    // handshake and next PC in the same cycle
    bus.inst_ready_i = 1'b1;
    bus.pc_i = 32'h8000_0004;
    bus.pc_valid_i = 1'b1;
    settle();
    chk("b2b_pc_ready", bus.pc_ready_o, 1);
    tick();
    bus.inst_ready_i = 1'b0;
    bus.pc_valid_i = 1'b0;

    // 4. flush while waiting for the response
    chk("b2b_ar_valid", bus.ar_valid_o, 1);
    chk("b2b_ar_addr", bus.ar_addr_o, 32'h8000_0004);
    bus.ar_ready_i = 1'b1;
    tick();
    bus.ar_ready_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("drop_r_ready", bus.r_ready_o, 1);
    chk("drop_pc_ready", bus.pc_ready_o, 0);
    bus.r_valid_i = 1'b1;
    bus.r_data_i = 32'hDEAD_BEEF;
    tick();
    bus.r_valid_i = 1'b0;
    chk("drop_no_inst", bus.inst_valid_o, 0);
    chk("drop_idle_pc_ready", bus.pc_ready_o, 1);
    issue(32'h8000_0100);
    chk("refetch_addr", bus.ar_addr_o, 32'h8000_0100);
    bus_reply(32'h0000_0513, 1'b0);
    chk("refetch_valid", bus.inst_valid_o, 1);
    chk("refetch_inst", bus.inst_o, 32'h0000_0513);
    chk("refetch_pc", bus.inst_pc_o, 32'h8000_0100);
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;

    // 5a. misaligned PC faults without touching the bus
    issue(32'h8000_0002);
    chk("mis_ar_valid", bus.ar_valid_o, 0);
    chk("mis_valid", bus.inst_valid_o, 1);
    chk("mis_fault", bus.inst_fault_o, 1);
    chk("mis_inst", bus.inst_o, 32'h13);
    chk("mis_pc", bus.inst_pc_o, 32'h8000_0002);
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;

    // 5b. bus error on an aligned fetch
    issue(32'h8000_000C);
    bus_reply(32'h1234_5678, 1'b1);
    chk("err_valid", bus.inst_valid_o, 1);
    chk("err_fault", bus.inst_fault_o, 1);
    chk("err_inst", bus.inst_o, 32'h13);
    chk("err_pc", bus.inst_pc_o, 32'h8000_000C);

    // flush in HOLD beats a simultaneous handshake and new PC
    bus.flush_i = 1'b1;
    bus.inst_ready_i = 1'b1;
    bus.pc_i = 32'h8000_0010;
    bus.pc_valid_i = 1'b1;
    settle();
    chk("hflush_pc_ready", bus.pc_ready_o, 0);
    tick();
    bus.flush_i = 1'b0;
    bus.inst_ready_i = 1'b0;
    bus.pc_valid_i = 1'b0;
    chk("hflush_valid", bus.inst_valid_o, 0);
    chk("hflush_ar_valid", bus.ar_valid_o, 0);

    // flush in REQ without acceptance withdraws the request
    issue(32'h8000_0020);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("rflush_ar_valid", bus.ar_valid_o, 0);
    chk("rflush_r_ready", bus.r_ready_o, 0);
    chk("rflush_pc_ready", bus.pc_ready_o, 1);

    // 6. reset in WAIT
    issue(32'h8000_0030);
    bus.ar_ready_i = 1'b1;
    tick();
    bus.ar_ready_i = 1'b0;
    chk("wrst_pre_r_ready", bus.r_ready_o, 1);
    rst_n = 1'b0;
    tick();
    chk("wrst_ar_valid", bus.ar_valid_o, 0);
    chk("wrst_r_ready", bus.r_ready_o, 0);
    chk("wrst_inst_valid", bus.inst_valid_o, 0);
    chk("wrst_inst", bus.inst_o, 32'h13);
    chk("wrst_inst_pc", bus.inst_pc_o, 0);
    chk("wrst_fault", bus.inst_fault_o, 0);
    chk("wrst_pc_ready", bus.pc_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
